// File: rtl/cpu_core_seq.sv
// Multi-cycle 16-bit-instruction CPU core with req/ack instruction and data memory ports.
// One sequencer owns PC, an 8-entry register file, two operand latches, the ALU and flags.
module cpu_core_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic [15:0]       dmem_addr,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_out,
    output logic [2:0]        wb_addr,
    output logic              za,
    output logic              zb,
    output logic              eq,
    output logic              gt,
    output logic              lt,
    output logic              halt,
    output logic              illegal
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StFetch2,
        StMem,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e state_q, state_d;

    logic              live_q;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       ir_q;
    logic [15:0]       opw_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] alu_q;
    logic [2:0]        wb_q;
    logic [4:0]        flags_q;
    logic              illegal_q;

    logic [1:0]        ot, mode;
    logic [2:0]        op1, op2;
    logic [3:0]        opc;
    logic              op_legal, instr_ok, is_halt, is_cmp, fetch_go;
    logic [DATA_W-1:0] result;
    logic              unused_ir;

    assign ot   = ir_q[15:14];
    assign mode = ir_q[13:12];
    assign op1  = ir_q[11:9];
    assign op2  = ir_q[8:6];
    assign opc  = ir_q[5:2];
    assign unused_ir = ^ir_q[1:0];

    // live_q keeps the first fetch request off until the cycle after reset release.
    assign fetch_go = live_q & en;

    always_comb begin
        op_legal = 1'b0;
        case (ot)
            2'b00:   op_legal = (opc == 4'h0) || (opc == 4'hF);
            2'b01:   op_legal = (opc <= 4'h4);
            2'b10:   op_legal = (opc <= 4'h5);
            default: op_legal = 1'b0;
        endcase
        instr_ok = op_legal && (mode != 2'b11);
        is_halt  = (ot == 2'b00) && (opc == 4'hF);
        is_cmp   = (ot == 2'b01) && (opc == 4'h4);
    end

    always_comb begin
        result = '0;
        case (ot)
            2'b00: result = b_q;
            2'b01: begin
                case (opc)
                    4'h0:    result = a_q + b_q;
                    4'h1:    result = a_q - b_q;
                    4'h2:    result = a_q + DATA_W'(1);
                    4'h3:    result = a_q - DATA_W'(1);
                    4'h4:    result = a_q - b_q;
                    default: result = '0;
                endcase
            end
            2'b10: begin
                case (opc)
                    4'h0:    result = a_q & b_q;
                    4'h1:    result = a_q | b_q;
                    4'h2:    result = a_q ^ b_q;
                    4'h3:    result = ~a_q;
                    4'h4:    result = a_q << 1;
                    4'h5:    result = a_q >> 1;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (fetch_go && imem_ack) state_d = StDecode;
            StDecode: begin
                if (!instr_ok || is_halt) begin
                    state_d = StHalt;
                end else if (mode == 2'b00) begin
                    state_d = StExec;
                end else begin
                    state_d = StFetch2;
                end
            end
            StFetch2: if (imem_ack) state_d = (mode == 2'b10) ? StMem : StExec;
            StMem:    if (dmem_ack) state_d = StExec;
            StExec:   state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        imem_req = ((state_q == StFetch) && fetch_go) || (state_q == StFetch2);
        dmem_req = (state_q == StMem);
        halt     = (state_q == StHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            pc_q      <= '0;
            ir_q      <= '0;
            opw_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            wb_q      <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            live_q <= 1'b1;
            case (state_q)
                StFetch: begin
                    if (fetch_go && imem_ack) begin
                        ir_q <= imem_rdata;
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                StDecode: begin
                    a_q <= regs_q[op1];
                    b_q <= regs_q[op2];
                    if (!instr_ok) illegal_q <= 1'b1;
                end
                StFetch2: begin
                    if (imem_ack) begin
                        opw_q <= imem_rdata;
                        b_q   <= DATA_W'(imem_rdata);
                        pc_q  <= pc_q + PC_W'(1);
                    end
                end
                StMem: if (dmem_ack) b_q <= dmem_rdata;
                StExec: begin
                    alu_q   <= result;
                    flags_q <= {a_q == '0, b_q == '0, a_q == b_q, a_q > b_q, a_q < b_q};
                end
                StWb: begin
                    if (!is_cmp) regs_q[op1] <= alu_q;
                    wb_q <= op1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign dmem_addr = opw_q;
    assign alu_out   = alu_q;
    assign wb_addr   = wb_q;
    assign {za, zb, eq, gt, lt} = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_core_seq.sv
// Self-checking bench for cpu_core_seq: directed vector table, multi-cycle corner sequences
// and randomized programs checked against an architectural reference model.
module tb_cpu_core_seq;

    localparam int DW = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          imem_req, imem_ack, dmem_req, dmem_ack;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_rdata, dmem_addr;
    logic [DW-1:0] dmem_rdata, alu_out;
    logic [2:0]    wb_addr;
    logic          za, zb, eq, gt, lt, halt, illegal;
    logic [4:0]    flg;

    logic [15:0] imem [16];
    logic [15:0] dmem [16];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic        stray_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mregs [8];
    logic [3:0]  mpc;

    cpu_core_seq #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .alu_out(alu_out), .wb_addr(wb_addr),
        .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt),
        .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign flg        = {za, zb, eq, gt, lt};
    assign imem_ack   = stray_ack | (imem_req && (icnt == iwait));
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr[3:0]];

    // Memory wait-state counters: count req cycles that have not been acked yet.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) icnt <= icnt + 1;
        else                       icnt <= 0;
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else                       dcnt <= 0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc(input logic [1:0] ot, input logic [1:0] mode,
                                        input logic [2:0] r1, input logic [2:0] r2,
                                        input logic [3:0] opc);
        return {ot, mode, r1, r2, opc, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called just after a clock edge in FETCH; the instruction must end in exactly cyc cycles.
    task automatic run_check(input string name, input logic [15:0] e_alu, input logic [2:0] e_wb,
                             input logic [4:0] e_flg, input logic [3:0] e_pc, input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
        check({name, " next-fetch"}, {imem_req, imem_addr}, {1'b1, e_pc});
        check({name, " alu_out"}, alu_out, e_alu);
        check({name, " wb_addr"}, wb_addr, e_wb);
        check({name, " flags"}, flg, e_flg);
    endtask

    task automatic do_reset(input logic en_v);
        rst_n = 1'b0;
        en    = en_v;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Architectural model: executes one instruction and predicts its cycle count.
    task automatic model_step(input logic [15:0] w0, input logic [15:0] w1,
                              output logic [15:0] res, output logic [4:0] fl, output int cyc);
        logic [1:0]  ot, mode;
        logic [2:0]  r1, r2;
        logic [3:0]  opc;
        logic [15:0] a, b;
        ot = w0[15:14]; mode = w0[13:12]; r1 = w0[11:9]; r2 = w0[8:6]; opc = w0[5:2];
        a = mregs[r1];
        if (mode == 2'd0)      b = mregs[r2];
        else if (mode == 2'd1) b = w1;
        else                   b = dmem[w1[3:0]];
        res = 16'h0;
        if (ot == 2'd0) res = b;
        else if (ot == 2'd1) begin
            if (opc == 4'd0) res = a + b;
            if (opc == 4'd1) res = a - b;
            if (opc == 4'd2) res = a + 16'd1;
            if (opc == 4'd3) res = a - 16'd1;
            if (opc == 4'd4) res = a - b;
        end else begin
            if (opc == 4'd0) res = a & b;
            if (opc == 4'd1) res = a | b;
            if (opc == 4'd2) res = a ^ b;
            if (opc == 4'd3) res = ~a;
            if (opc == 4'd4) res = a << 1;
            if (opc == 4'd5) res = a >> 1;
        end
        fl = {a == 16'h0, b == 16'h0, a == b, a > b, a < b};
        if (!(ot == 2'd1 && opc == 4'd4)) mregs[r1] = res;
        mpc = mpc + ((mode == 2'd0) ? 4'd1 : 4'd2);
        cyc = 4 + iwait + ((mode != 2'd0) ? 1 + iwait : 0) + ((mode == 2'd2) ? 1 + dwait : 0);
    endtask

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] alu;
        logic [2:0]  wb;
        logic [4:0]  fl;
        logic [3:0]  pc;
        int          cyc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [3:0]  p;
        logic        any_req;
        logic [15:0] bad [4];
        logic [15:0] w0, w1, res;
        logic [4:0]  fl;
        logic [1:0]  rot, rmode;
        logic [3:0]  ropc;
        int          cyc;

        // Flags are {za, zb, eq, gt, lt}; PC is 4 bits and the program fills all 16 words.
        tbl[0]  = '{enc(0, 1, 1, 0, 0), 16'h1234, 16'h1234, 3'd1, 5'b10001, 4'd2,  5};
        tbl[1]  = '{enc(1, 0, 1, 1, 0), 16'h0,    16'h2468, 3'd1, 5'b00100, 4'd3,  4};
        tbl[2]  = '{enc(0, 1, 3, 0, 0), 16'h0005, 16'h0005, 3'd3, 5'b10001, 4'd5,  5};
        tbl[3]  = '{enc(1, 1, 3, 0, 4), 16'h0005, 16'h0000, 3'd3, 5'b00100, 4'd7,  5};
        tbl[4]  = '{enc(1, 0, 3, 1, 2), 16'h0,    16'h0006, 3'd3, 5'b00001, 4'd8,  4};
        tbl[5]  = '{enc(2, 0, 1, 3, 2), 16'h0,    16'h246E, 3'd1, 5'b00010, 4'd9,  4};
        tbl[6]  = '{enc(2, 0, 3, 0, 4), 16'h0,    16'h000C, 3'd3, 5'b01010, 4'd10, 4};
        tbl[7]  = '{enc(2, 0, 0, 0, 3), 16'h0,    16'hFFFF, 3'd0, 5'b11100, 4'd11, 4};
        tbl[8]  = '{enc(1, 0, 2, 2, 3), 16'h0,    16'hFFFF, 3'd2, 5'b11100, 4'd12, 4};
        tbl[9]  = '{enc(2, 0, 0, 3, 5), 16'h0,    16'h7FFF, 3'd0, 5'b00010, 4'd13, 4};
        tbl[10] = '{enc(2, 1, 0, 0, 0), 16'h00F0, 16'h00F0, 3'd0, 5'b00010, 4'd15, 5};
        tbl[11] = '{enc(2, 0, 4, 0, 1), 16'h0,    16'h00F0, 3'd4, 5'b10001, 4'd0,  4};

        for (int i = 0; i < 16; i++) begin
            imem[i] = 16'h0;
            dmem[i] = 16'h0;
        end
        p = 4'd0;
        for (int i = 0; i < 12; i++) begin
            imem[p] = tbl[i].w0;
            p = p + 4'd1;
            if (tbl[i].w0[13:12] != 2'b00) begin
                imem[p] = tbl[i].w1;
                p = p + 4'd1;
            end
        end

        // Reset held with en=1: all outputs quiet.
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", {imem_req, imem_addr, dmem_req, halt, illegal, wb_addr}, 32'h0);
        check("reset data", {alu_out, dmem_addr}, 32'h0);
        check("reset flags", flg, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset release req", {imem_req, imem_addr}, {1'b1, 4'd0});

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].alu, tbl[i].wb, tbl[i].fl, tbl[i].pc,
                      tbl[i].cyc);
        end

        // Direct-mode SUB with two data wait states: 8 cycles.
        imem[0] = enc(1, 2, 2, 0, 1);
        imem[1] = 16'h0007;
        dmem[7] = 16'hFFFF;
        dwait   = 2;
        do_reset(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("direct mem req", {dmem_req, dmem_addr}, {1'b1, 16'h0007});
        repeat (2) @(posedge clk);
        #1;
        check("direct mem hold", {dmem_req, dmem_addr}, {1'b1, 16'h0007});
        run_check("sub direct", 16'h0001, 3'd2, 5'b10001, 4'd2, 3);
        dwait = 0;

        // HALT opcode: terminal, not illegal, no further fetches.
        imem[2] = enc(0, 0, 0, 0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check("halt op", {halt, illegal}, 2'b10);
        any_req = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            any_req |= imem_req;
        end
        check("halt no fetch", {any_req, alu_out}, {1'b0, 16'h0001});

        // Illegal encodings: OT=11, mode=11, bad arith opcode, bad move opcode.
        bad[0] = 16'hC000;
        bad[1] = enc(1, 3, 1, 1, 0);
        bad[2] = enc(1, 0, 1, 1, 5);
        bad[3] = enc(0, 0, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            imem[0] = enc(0, 1, 1, 0, 0);
            imem[1] = 16'hABCD;
            imem[2] = bad[k];
            do_reset(1'b1);
            run_check($sformatf("pre-illegal%0d", k), 16'hABCD, 3'd1, 5'b10001, 4'd2, 5);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("illegal%0d trap", k), {halt, illegal}, 2'b11);
            any_req = 1'b0;
            repeat (5) begin
                @(posedge clk);
                #1;
                any_req |= imem_req;
            end
            check($sformatf("illegal%0d frozen", k), {any_req, alu_out, wb_addr, flg},
                  {1'b0, 16'hABCD, 3'd1, 5'b10001});
        end

        // en=0 at FETCH: no request until en rises.
        imem[0] = enc(0, 1, 5, 0, 0);
        imem[1] = 16'h0042;
        do_reset(1'b0);
        any_req = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            any_req |= imem_req;
        end
        check("en low idle", {any_req, imem_addr}, 32'h0);
        en = 1'b1;
        #1;
        check("en high req", imem_req, 1'b1);
        run_check("mov after en", 16'h0042, 3'd5, 5'b10001, 4'd2, 5);

        // Reset while a fetch is waiting for ack, with a stray ack in the release cycle.
        iwait   = 3;
        imem[0] = enc(0, 1, 6, 0, 0);
        imem[1] = 16'h0777;
        repeat (2) @(posedge clk);
        #1;
        check("pending fetch", {imem_req, imem_addr}, {1'b1, 4'd2});
        rst_n = 1'b0;
        #1;
        check("mid reset", {imem_req, imem_addr, halt, alu_out}, 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        iwait     = 0;
        check("stray ack ignored", {imem_req, imem_addr}, {1'b1, 4'd0});
        run_check("mov after reset", 16'h0777, 3'd6, 5'b10001, 4'd2, 5);

        // Randomized programs with random wait states against the model.
        for (int i = 0; i < 16; i++) dmem[i] = 16'($urandom);
        iwait = 0;
        dwait = 0;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        mpc = 4'd0;
        for (int k = 0; k < 60; k++) begin
            rot   = 2'($urandom_range(0, 2));
            rmode = 2'($urandom_range(0, 2));
            if (rot == 2'd0)      ropc = 4'd0;
            else if (rot == 2'd1) ropc = 4'($urandom_range(0, 4));
            else                  ropc = 4'($urandom_range(0, 5));
            w0 = enc(rot, rmode, 3'($urandom), 3'($urandom), ropc);
            w1 = 16'($urandom);
            imem[mpc] = w0;
            imem[mpc + 4'd1] = w1;
            iwait = $urandom_range(0, 2);
            dwait = $urandom_range(0, 2);
            model_step(w0, w1, res, fl, cyc);
            run_check($sformatf("rand%0d", k), res, w0[11:9], fl, mpc, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_core_seq.md
# cpu_core_seq

Parametrised multi-cycle 16-bit-instruction CPU core: one sequencer owning PC, 8-entry register file, two operand latches, ALU and flags. Replaces the hard-wired ROM/RAM top with req/ack handshakes to instruction and data memory, so either memory may insert wait states. Adds a DATA_W-wide datapath, two-word instructions (immediate and direct), HALT and illegal-instruction trapping.

## Interface
- DATA_W, 16, register/ALU width (≥16); immediate words zero-extended to DATA_W
- PC_W, 16, instruction address width; PC wraps modulo 2^PC_W
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable, sampled only at instruction boundary (FETCH)
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  instruction/operand word
- dmem_req  out  1  data read request (direct mode)
- dmem_addr  out  16  data address (second instruction word)
- dmem_ack  in  1  read data valid this cycle
- dmem_rdata  in  DATA_W  read data
- alu_out  out  DATA_W  last ALU result (registered)
- wb_addr  out  3  last destination register
- za, zb, eq, gt, lt  out  1 each  flags: A==0, B==0, A==B, A>B, A<B (unsigned)
- halt  out  1  core stopped (HALT or illegal)
- illegal  out  1  sticky illegal-instruction flag

## Operation
- Word: [15:14] OT (00 move, 01 arith, 10 logic, 11 illegal), [13:12] mode (00 register, 01 immediate, 10 direct, 11 illegal), [11:9] op1/dest, [8:6] op2, [5:2] opcode, [1:0] ignored.
- A = R[op1]. B = R[op2] (mode 00), second word zero-extended (01), dmem_rdata at address second word (10).
- OT 00: 0000 MOV R[op1]←B; 1111 HALT. OT 01: 0000 ADD A+B, 0001 SUB A−B, 0010 INC A+1, 0011 DEC A−1, 0100 CMP (flags only, no writeback). OT 10: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT ~A, 0100 SHL A<<1, 0101 SHR A>>1. Any other code is illegal.
- All results truncated to DATA_W (wrap, no carry out).
- Flags are updated in EXEC for every legal non-HALT instruction, from A and B (B computed per mode; INC/DEC/NOT/shift still compare against B).
- States: FETCH → DECODE → [FETCH2 if mode 01/10] → [MEM if mode 10] → EXEC → WB → FETCH. HALT is terminal; only rst_n leaves it.
- FETCH: if en=0, imem_req stays low and state holds. Otherwise imem_req=1; on imem_ack latch the word, PC←PC+1. FETCH2 is identical (PC also increments); en is ignored there.
- DECODE: illegal OT/mode/opcode → illegal=1, HALT; no register or flag change. HALT opcode → HALT.
- MEM: dmem_req=1, dmem_addr stable until dmem_ack; latch dmem_rdata.
- WB: R[op1]←result unless CMP; wb_addr←op1; alu_out updated in EXEC (CMP included).
- Handshake: req rises in the first cycle of its state and stays high with stable address until the ack cycle; it is low the following cycle. Ack may arrive in the first req cycle. Ack while req is low is ignored.
- Reset (any state, including mid-handshake): PC=0, R0–R7=0, alu_out=0, wb_addr=0, all flags 0, halt=0, illegal=0, imem_req=dmem_req=0, state FETCH. A late ack after reset is ignored unless req is high.

## Timing
- Zero-wait memories: register-mode instruction 4 cycles, immediate 5, direct 6.
- Each memory wait cycle adds exactly one cycle.
- Written register is readable as operand by the next instruction (WB completes before next DECODE).
- halt rises the cycle after DECODE of HALT or illegal; imem_req stays 0 thereafter.

## Test plan
- Reset: hold rst_n=0 → every output 0, imem_addr=0. Release with en=1 → imem_req=1 next edge.
- MOV R1,#0x1234 (immediate) then ADD R1,R1 (register), zero-wait → R1=0x2468 (alu_out), wb_addr=1, PC=3, total 9 cycles.
- Direct mode, dmem data 0xFFFF with 2 wait states, SUB R2(=0) → alu_out=0x0001, lt=1, za=1; 8 cycles for the instruction.
- CMP R3(=5),#5 → eq=1, gt=lt=0, R3 unchanged, alu_out=0; PC_W=4 with PC at 15 → fetch wraps to address 0.
- Illegal OT=11 word → illegal=1, halt=1, registers unchanged, no further imem_req. en=0 at FETCH → no req until en=1.
- rst_n pulse while imem_req high awaiting ack → state FETCH, PC=0; stray ack in reset-release cycle is ignored.
